coherence_bus_arbiter: RTL and testbench

// - Shares one snooping bus among NUM_CACHES MSI cache controllers.
// - Each controller posts one bus message (read miss, invalidate, write miss, write-back)

---
 rtl/coherence_bus_arbiter_pkg.sv | 41 ++++
 rtl/coherence_bus_arbiter_rr_picker.sv | 33 +++
 rtl/coherence_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_coherence_bus_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared definitions for the snooping-bus arbiter: message codes (also used by
// the per-cache MSI controllers), operation classes and arbiter state encodings.
package coherence_bus_arbiter_pkg;

    localparam int IDX_W = 2;
    localparam int MSG_W = 3;
    localparam int TMR_W = 4;

    localparam logic [MSG_W-1:0] MSG_EMPTY            = 3'd0;
    localparam logic [MSG_W-1:0] MSG_READ_MISS        = 3'd1;
    localparam logic [MSG_W-1:0] MSG_INVALIDATE       = 3'd2;
    localparam logic [MSG_W-1:0] MSG_WRITE_MISS       = 3'd3;
    localparam logic [MSG_W-1:0] MSG_WRITE_BACK       = 3'd4;
    localparam logic [MSG_W-1:0] MSG_WRITE_BACK_CACHE = 3'd5;

    // Encodings are visible on state_dbg and feed a HEX decoder, so they are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_BROADCAST = 3'd2,
        ST_SNOOP     = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_DONE      = 3'd5
    } arb_state_e;

    typedef enum logic [1:0] {
        OP_SNOOP   = 2'd0,
        OP_MEMWB   = 2'd1,
        OP_ILLEGAL = 2'd2
    } arb_op_e;

    // Classifies a posted message into the path the arbiter takes after GRANT.
    function automatic arb_op_e msg_op(input logic [MSG_W-1:0] msg);
        case (msg)
            MSG_READ_MISS, MSG_INVALIDATE, MSG_WRITE_MISS: return OP_SNOOP;
            MSG_WRITE_BACK, MSG_WRITE_BACK_CACHE:          return OP_MEMWB;
            default:                                       return OP_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/coherence_bus_arbiter_rr_picker.sv
// Round-robin picker: first requester strictly after the pointer, wrapping.
module coherence_bus_arbiter_rr_picker
    import coherence_bus_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    int   j;
    logic found;

    // Scan N positions starting one past the pointer; the pointer itself is checked last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 1; i <= N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Snooping-bus arbiter for NUM_CACHES MSI controllers: round-robin grant,
// broadcast, snoop-reply collection, optional memory write-back, completion.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | no owner; pick a winner when any req is high
//  GRANT     | owner latched; classify message
//  BROADCAST | one-cycle bus_valid strobe to snoopers
//  SNOOP     | accumulate snoop_done / snoop_wb from non-owners
//  WRITEBACK | hold mem_wb_req until mem_wb_ack
//  DONE      | pulse done[owner] (and err if aborted); pointer <- owner
module coherence_bus_arbiter
    import coherence_bus_arbiter_pkg::*;
#(
    parameter int NUM_CACHES    = 2,
    parameter int ADDR_W        = 4,
    parameter int SNOOP_TIMEOUT = 15
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CACHES-1:0]        req,
    input  logic [3*NUM_CACHES-1:0]      req_msg,
    input  logic [ADDR_W*NUM_CACHES-1:0] req_addr,
    output logic [NUM_CACHES-1:0]        gnt,
    output logic [NUM_CACHES-1:0]        done,
    output logic                         err,
    output logic                         bus_valid,
    output logic [2:0]                   bus_msg,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [1:0]                   bus_src,
    input  logic [NUM_CACHES-1:0]        snoop_done,
    input  logic [NUM_CACHES-1:0]        snoop_wb,
    output logic                         mem_wb_req,
    output logic [ADDR_W-1:0]            mem_wb_addr,
    input  logic                         mem_wb_ack,
    output logic                         busy,
    output logic [2:0]                   state_dbg
);

    // Down-counter reload: the last allowed cycle is the one where it reads zero.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SNOOP_TIMEOUT - 1);

    arb_state_e              state_q, state_d;
    logic [NUM_CACHES-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [MSG_W-1:0]        msg_q, msg_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [NUM_CACHES-1:0]   acc_done_q, acc_done_d;
    logic [NUM_CACHES-1:0]   acc_wb_q, acc_wb_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic                    err_q, err_d;

    logic [NUM_CACHES-1:0]   pick_gnt;
    logic [IDX_W-1:0]        pick_idx;
    logic [NUM_CACHES-1:0]   seen_done;
    logic [NUM_CACHES-1:0]   seen_wb;

    coherence_bus_arbiter_rr_picker #(.N(NUM_CACHES)) u_picker (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // State and datapath registers; reset drops any in-flight transaction silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= IDX_W'(NUM_CACHES - 1);
            msg_q      <= '0;
            addr_q     <= '0;
            acc_done_q <= '0;
            acc_wb_q   <= '0;
            tmr_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            msg_q      <= msg_d;
            addr_q     <= addr_d;
            acc_done_q <= acc_done_d;
            acc_wb_q   <= acc_wb_d;
            tmr_q      <= tmr_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic; snoop replies include the current cycle so bits present at SNOOP entry count.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        msg_d      = msg_q;
        addr_d     = addr_q;
        acc_done_d = acc_done_q;
        acc_wb_d   = acc_wb_q;
        tmr_d      = tmr_q;
        err_d      = err_q;
        seen_done  = acc_done_q | (snoop_done & ~gnt_q);
        seen_wb    = acc_wb_q | (snoop_wb & ~gnt_q);

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = pick_gnt;
                    owner_d = pick_idx;
                    msg_d   = req_msg[3*pick_idx +: 3];
                    addr_d  = req_addr[ADDR_W*pick_idx +: ADDR_W];
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                case (msg_op(msg_q))
                    OP_SNOOP: state_d = ST_BROADCAST;
                    OP_MEMWB: begin
                        state_d = ST_WRITEBACK;
                        tmr_d   = TMR_LOAD;
                    end
                    default: begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                endcase
            end
            ST_BROADCAST: begin
                state_d    = ST_SNOOP;
                tmr_d      = TMR_LOAD;
                acc_done_d = '0;
                acc_wb_d   = '0;
            end
            ST_SNOOP: begin
                acc_done_d = seen_done;
                acc_wb_d   = seen_wb;
                if (seen_done == ~gnt_q) begin
                    if (!(|seen_wb)) begin
                        state_d = ST_DONE;
                    end else if (msg_q == MSG_INVALIDATE) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_WRITEBACK;
                        tmr_d   = TMR_LOAD;
                    end
                end else if (tmr_q == '0) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_WRITEBACK: begin
                if (mem_wb_ack) begin
                    state_d = ST_DONE;
                end else if (tmr_q == '0) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_DONE: begin
                ptr_d      = owner_q;
                gnt_d      = '0;
                acc_done_d = '0;
                acc_wb_d   = '0;
                tmr_d      = '0;
                err_d      = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign gnt         = gnt_q;
    assign done        = (state_q == ST_DONE) ? gnt_q : '0;
    assign err         = (state_q == ST_DONE) && err_q;
    assign bus_valid   = (state_q == ST_BROADCAST);
    assign bus_msg     = bus_valid ? msg_q : '0;
    assign bus_addr    = bus_valid ? addr_q : '0;
    assign bus_src     = bus_valid ? owner_q : '0;
    assign mem_wb_req  = (state_q == ST_WRITEBACK);
    assign mem_wb_addr = mem_wb_req ? addr_q : '0;
    assign busy        = (state_q != ST_IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter (NUM_CACHES=2, ADDR_W=4, SNOOP_TIMEOUT=15).
module tb_coherence_bus_arbiter;

    logic       clock;
    logic       reset;
    logic [1:0] req;
    logic [5:0] req_msg;
    logic [7:0] req_addr;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       err;
    logic       bus_valid;
    logic [2:0] bus_msg;
    logic [3:0] bus_addr;
    logic [1:0] bus_src;
    logic [1:0] snoop_done;
    logic [1:0] snoop_wb;
    logic       mem_wb_req;
    logic [3:0] mem_wb_addr;
    logic       mem_wb_ack;
    logic       busy;
    logic [2:0] state_dbg;

    int vectors = 0;
    int miscompares = 0;

    coherence_bus_arbiter #(.NUM_CACHES(2), .ADDR_W(4), .SNOOP_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .req(req), .req_msg(req_msg), .req_addr(req_addr),
        .gnt(gnt), .done(done), .err(err), .bus_valid(bus_valid), .bus_msg(bus_msg),
        .bus_addr(bus_addr), .bus_src(bus_src), .snoop_done(snoop_done), .snoop_wb(snoop_wb),
        .mem_wb_req(mem_wb_req), .mem_wb_addr(mem_wb_addr), .mem_wb_ack(mem_wb_ack),
        .busy(busy), .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"},  32'(gnt), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"},  32'(err), 0);
        chk({tag, "_bv"},   32'(bus_valid), 0);
        chk({tag, "_wbr"},  32'(mem_wb_req), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_st"},   32'(state_dbg), 0);
    endtask

    initial begin
        reset = 1'b1; req = '0; req_msg = '0; req_addr = '0;
        snoop_done = '0; snoop_wb = '0; mem_wb_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk_quiet("reset");

        // Single request: cache1 ReadMiss addr 5
        req = 2'b10; req_msg = 6'b001_000; req_addr = 8'h50;
        tick();
        chk("s_gnt", 32'(gnt), 2); chk("s_st_grant", 32'(state_dbg), 1); chk("s_bv0", 32'(bus_valid), 0);
        tick();
        chk("s_bv", 32'(bus_valid), 1); chk("s_msg", 32'(bus_msg), 1);
        chk("s_addr", 32'(bus_addr), 5); chk("s_src", 32'(bus_src), 1);
        snoop_done = 2'b01;
        tick();
        chk("s_st_snoop", 32'(state_dbg), 3); chk("s_done0", 32'(done), 0);
        tick();
        chk("s_done", 32'(done), 2); chk("s_err", 32'(err), 0); chk("s_gnt_done", 32'(gnt), 2);
        req = '0; snoop_done = '0;
        tick();
        chk_quiet("s_idle");

        // Contention: both requesters held; cache0 first, then cache1
        req = 2'b11; req_msg = 6'b001_001; req_addr = 8'h73; snoop_done = 2'b11;
        tick();
        chk("c_gnt0", 32'(gnt), 1);
        tick();
        chk("c_src0", 32'(bus_src), 0); chk("c_addr0", 32'(bus_addr), 3);
        tick(); tick();
        chk("c_done0", 32'(done), 1);
        tick();
        chk("c_idle", 32'(gnt), 0);
        tick();
        chk("c_gnt1", 32'(gnt), 2);
        tick();
        chk("c_src1", 32'(bus_src), 1); chk("c_addr1", 32'(bus_addr), 7);
        tick(); tick();
        chk("c_done1", 32'(done), 2);
        req = '0; snoop_done = '0;
        tick();

        // Write-back path: cache0 WriteMiss addr 9, cache1 holds it Exclusive
        req = 2'b01; req_msg = 6'b000_011; req_addr = 8'h09;
        snoop_done = 2'b10; snoop_wb = 2'b10;
        tick(); tick();
        chk("w_msg", 32'(bus_msg), 3);
        tick(); tick();
        snoop_done = '0; snoop_wb = '0;
        chk("w_st", 32'(state_dbg), 4); chk("w_req", 32'(mem_wb_req), 1); chk("w_addr", 32'(mem_wb_addr), 9);
        tick(); tick();
        chk("w_req_hold", 32'(mem_wb_req), 1);
        mem_wb_ack = 1'b1;
        tick();
        chk("w_done", 32'(done), 1); chk("w_err", 32'(err), 0); chk("w_req_drop", 32'(mem_wb_req), 0);
        mem_wb_ack = 1'b0; req = '0;
        tick();

        // Direct write-back: cache1 msg 5 addr 12
        req = 2'b10; req_msg = 6'b101_000; req_addr = 8'hC0;
        tick(); tick();
        chk("d_bv", 32'(bus_valid), 0); chk("d_req", 32'(mem_wb_req), 1); chk("d_addr", 32'(mem_wb_addr), 12);
        mem_wb_ack = 1'b1;
        tick();
        chk("d_done", 32'(done), 2); chk("d_err", 32'(err), 0);
        mem_wb_ack = 1'b0; req = '0;
        tick();

        // Illegal codes: cache0 msg 0, then cache1 msg 7
        req = 2'b01; req_msg = 6'b000_000;
        tick(); tick();
        chk("i0_done", 32'(done), 1); chk("i0_err", 32'(err), 1); chk("i0_bv", 32'(bus_valid), 0);
        req = '0;
        tick();
        req = 2'b10; req_msg = 6'b111_000;
        tick();
        chk("i7_bv", 32'(bus_valid), 0);
        tick();
        chk("i7_done", 32'(done), 2); chk("i7_err", 32'(err), 1);
        req = '0;
        tick();

        // Snoop timeout: cache0 ReadMiss, no snoop replies -> 15 cycles in SNOOP
        req = 2'b01; req_msg = 6'b000_001; req_addr = 8'h02;
        tick(); tick(); tick();
        chk("t_st_first", 32'(state_dbg), 3);
        for (int k = 0; k < 14; k++) tick();
        chk("t_st_last", 32'(state_dbg), 3); chk("t_nodone", 32'(done), 0);
        tick();
        chk("t_done", 32'(done), 1); chk("t_err", 32'(err), 1);
        req = '0;
        tick();

        // Invalidate answered with a write-back flag -> protocol error
        req = 2'b10; req_msg = 6'b010_000; req_addr = 8'h40;
        snoop_done = 2'b01; snoop_wb = 2'b01;
        tick(); tick(); tick(); tick();
        chk("v_done", 32'(done), 2); chk("v_err", 32'(err), 1);
        req = '0; snoop_done = '0; snoop_wb = '0;
        tick();

        // Ack on the last allowed WRITEBACK cycle wins over timeout
        req = 2'b01; req_msg = 6'b000_100; req_addr = 8'h06;
        tick(); tick();
        for (int k = 0; k < 14; k++) tick();
        chk("a_st", 32'(state_dbg), 4);
        mem_wb_ack = 1'b1;
        tick();
        chk("a_done", 32'(done), 1); chk("a_err", 32'(err), 0);
        mem_wb_ack = 1'b0; req = '0;
        tick();

        // Reset during WRITEBACK: outputs clear at once, no done, cache0 priority afterwards
        req = 2'b10; req_msg = 6'b100_100; req_addr = 8'hA1;
        tick(); tick();
        chk("r_wbr", 32'(mem_wb_req), 1); chk("r_addr", 32'(mem_wb_addr), 10);
        req = 2'b11;
        reset = 1'b1;
        #1;
        chk_quiet("r_async");
        tick();
        chk("r_nodone", 32'(done), 0);
        reset = 1'b0;
        tick();
        chk("r_gnt", 32'(gnt), 1);
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
